// File: rtl/uart_rx_if.sv
// Serial line and receive-result bundle for uart_rx.
// master drives the line and consumes results; slave is the receiver.
interface uart_rx_if;
  logic       i_rxSerial;
  logic       i_errorClear;
  logic [7:0] o_rxData;
  logic       o_rxDone;
  logic       o_rxBusy;
  logic       o_frameError;
  logic       o_break;
  logic       o_errorSticky;

  modport master (
    output i_rxSerial, i_errorClear,
    input  o_rxData, o_rxDone, o_rxBusy, o_frameError, o_break, o_errorSticky
  );

  modport slave (
    input  i_rxSerial, i_errorClear,
    output o_rxData, o_rxDone, o_rxBusy, o_frameError, o_break, o_errorSticky
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line sync, mid-bit sampling, framing/break detection.
// Done/frameError/break are registered one-cycle pulses in the cycle after the stop sample.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 1000
) (
  input  logic     i_clock,
  input  logic     i_resetN,
  uart_rx_if.slave rx
);
  if (CLOCKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_rx: CLOCKS_PER_BIT must be at least 4");
  end

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLOCKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  // Assertion is immediate; release is retimed onto i_clock.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0] sync_q;
  logic       rx_sync;

  always_ff @(posedge i_clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx.i_rxSerial};
    end
  end

  assign rx_sync = sync_q[1];

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             busy_q;
  logic             ferr_q;
  logic             brk_q;
  logic             sticky_q;

  always_ff @(posedge i_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
      // A framing error later in this block overrides the clear.
      if (rx.i_errorClear) begin
        sticky_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_sync) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == HALF_BIT) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (rx_sync) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end

        DATA: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end

        STOP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (rx_sync) begin
              data_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q   <= 1'b1;
              brk_q    <= (shift_q == 8'h00);
              sticky_q <= 1'b1;
              state_q  <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          cnt_q <= '0;
          if (rx_sync) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_rxData      = data_q;
  assign rx.o_rxDone      = done_q;
  assign rx.o_rxBusy      = busy_q;
  assign rx.o_frameError  = ferr_q;
  assign rx.o_break       = brk_q;
  assign rx.o_errorSticky = sticky_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table, glitch/break/reset sequences and random loopback.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB    = 16;
  localparam int HALF   = CPB / 2;
  // From the negedge the pin falls on to the negedge the result pulse is seen.
  localparam int EV_LAT = 4 + HALF + 9 * CPB;

  typedef struct {
    int         cyc;
    logic       done;
    logic       ferr;
    logic       brk;
    logic       sticky;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         per;
    int         gap;
    logic [3:0] exp_flags;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic i_resetN;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  ev_q[$];

  uart_rx_if bus ();

  uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
    .i_clock (clk),
    .i_resetN(i_resetN),
    .rx      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (bus.o_rxDone || bus.o_frameError || bus.o_break) begin
      e.cyc    = cyc;
      e.done   = bus.o_rxDone;
      e.ferr   = bus.o_frameError;
      e.brk    = bus.o_break;
      e.sticky = bus.o_errorSticky;
      e.data   = bus.o_rxData;
      ev_q.push_back(e);
    end
  end

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Sender bit j occupies [j*per/100, (j+1)*per/100) cycles; per is in 1/100 cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                            input int gap, output int n0);
    logic [9:0] fb;
    int         len;
    fb  = {stop, b, 1'b0};
    len = (10 * per) / 100;
    n0  = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == 0) n0 = cyc;
      bus.i_rxSerial = fb[(c * 100) / per];
    end
    for (int c = 0; c < gap; c++) begin
      @(negedge clk);
      bus.i_rxSerial = 1'b1;
    end
  endtask

  task automatic check_ev(input string name, input int idx, input int exp_cyc,
                          input logic [3:0] exp_flags, input logic [7:0] exp_data);
    if (idx < ev_q.size()) begin
      check($sformatf("%s cyc", name), ev_q[idx].cyc, exp_cyc);
      check($sformatf("%s flags", name),
            {ev_q[idx].done, ev_q[idx].ferr, ev_q[idx].brk, ev_q[idx].sticky}, exp_flags);
      check($sformatf("%s data", name), ev_q[idx].data, exp_data);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: got no event want one at cyc %0d", name, exp_cyc);
    end
  endtask

  initial begin
    vec_t       vecs[6];
    int         n0s[6];
    int         n0;
    int         n0b;
    int         busy_cnt;
    int         busy_first;
    int         nerr;
    logic [9:0] fb;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    // {byte, stop, period, idle gap, {done,ferr,brk,sticky}, data seen at the pulse}
    vecs[0] = '{8'hA5, 1'b1, 1600, 0,       4'b1000, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1600, 0,       4'b1000, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1600, 0,       4'b1000, 8'hFF};
    vecs[3] = '{8'h55, 1'b1, 1568, 0,       4'b1000, 8'h55};
    vecs[4] = '{8'h3C, 1'b0, 1600, 2 * CPB, 4'b0101, 8'h55};
    vecs[5] = '{8'h7E, 1'b1, 1600, CPB,     4'b1001, 8'h7E};

    bus.i_rxSerial   = 1'b1;
    bus.i_errorClear = 1'b0;
    i_resetN         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data", bus.o_rxData, 8'h00);
    check("reset flags", {bus.o_rxDone, bus.o_rxBusy, bus.o_frameError,
                          bus.o_break, bus.o_errorSticky}, 5'b00000);
    i_resetN = 1'b1;
    repeat (5) @(negedge clk);
    check("idle busy", bus.o_rxBusy, 1'b0);

    ev_q.delete();
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].dat, vecs[i].stop, vecs[i].per, vecs[i].gap, n0s[i]);
    end
    repeat (4) @(negedge clk);
    check("table event count", ev_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_ev($sformatf("vec%0d", i), i, n0s[i] + EV_LAT, vecs[i].exp_flags, vecs[i].exp_data);
    end

    @(negedge clk);
    bus.i_errorClear = 1'b1;
    @(negedge clk);
    bus.i_errorClear = 1'b0;
    check("sticky cleared", bus.o_errorSticky, 1'b0);

    ev_q.delete();
    busy_cnt   = 0;
    busy_first = -1;
    n0         = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) n0 = cyc;
      if (bus.o_rxBusy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc - n0;
      end
      bus.i_rxSerial = (c < 3) ? 1'b0 : 1'b1;
    end
    check("glitch busy start", busy_first, 3);
    check("glitch busy length", busy_cnt, HALF + 1);
    check("glitch events", ev_q.size(), 0);
    check("glitch sticky", bus.o_errorSticky, 1'b0);

    // Break with the clear held high: the new error must still set the sticky flag.
    ev_q.delete();
    bus.i_errorClear = 1'b1;
    n0 = 0;
    for (int c = 0; c < 20 * CPB; c++) begin
      @(negedge clk);
      if (c == 0) n0 = cyc;
      if (c == 20 * CPB - 1) check("break wait busy", bus.o_rxBusy, 1'b1);
      bus.i_rxSerial = 1'b0;
    end
    @(negedge clk);
    bus.i_rxSerial = 1'b1;
    repeat (6) @(negedge clk);
    check("break released busy", bus.o_rxBusy, 1'b0);
    check("break sticky cleared", bus.o_errorSticky, 1'b0);
    bus.i_errorClear = 1'b0;
    send_frame(8'h81, 1'b1, 1600, CPB, n0b);
    check("break event count", ev_q.size(), 2);
    check_ev("break", 0, n0 + EV_LAT, 4'b0111, 8'h7E);
    check_ev("after break", 1, n0b + EV_LAT, 4'b1000, 8'h81);

    send_frame(8'h3C, 1'b0, 1600, 2 * CPB, n0);
    check("sticky before reset", bus.o_errorSticky, 1'b1);
    ev_q.delete();
    fb = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      bus.i_rxSerial = fb[(c * 100) / 1600];
    end
    check("busy before reset", bus.o_rxBusy, 1'b1);
    @(negedge clk);
    i_resetN = 1'b0;
    #1;
    check("midframe reset data", bus.o_rxData, 8'h00);
    check("midframe reset flags", {bus.o_rxDone, bus.o_rxBusy, bus.o_frameError,
                                   bus.o_break, bus.o_errorSticky}, 5'b00000);
    bus.i_rxSerial = 1'b1;
    repeat (3) @(negedge clk);
    i_resetN = 1'b1;
    repeat (200) @(negedge clk);
    check("post reset events", ev_q.size(), 0);
    check("post reset busy", bus.o_rxBusy, 1'b0);
    check("post reset data", bus.o_rxData, 8'h00);

    ev_q.delete();
    for (int i = 0; i < 256; i++) begin
      int per_sel;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      per_sel = $urandom_range(0, 2);
      send_frame(b, 1'b1, (per_sel == 0) ? 1568 : (per_sel == 1) ? 1600 : 1632,
                 $urandom_range(0, CPB), n0);
    end
    repeat (20) @(negedge clk);
    check("loopback count", ev_q.size(), 256);
    nerr = 0;
    for (int i = 0; i < ev_q.size(); i++) begin
      if (ev_q[i].ferr || ev_q[i].brk) nerr++;
      if (i < exp_q.size()) check($sformatf("loopback byte %0d", i), ev_q[i].data, exp_q[i]);
    end
    check("loopback errors", nerr, 0);
    check("loopback sticky", bus.o_errorSticky, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous 8N1 UART receiver, the receive-side counterpart of `uart_tx` in the PMIC design. It samples `i_uartRx` on the internal 4.16 MHz oscillator clock and recovers bytes at the same baud divisor as the transmitter. It reports each received byte with a one-cycle done strobe. It flags framing errors and break conditions, and holds a sticky error suitable for driving `o_uartError`.

## Interface
- `CLOCKS_PER_BIT`, default 1000, is the clock cycles per bit, matching `uart_tx`. The legal minimum is 4; a smaller value is a synthesis-time error.
- `i_clock`: input, 1 bit, system clock from the OSCH output.
- `i_resetN`: input, 1 bit. Reset is asynchronous and active-low. Asserting it clears all state immediately; release is synchronous to `i_clock`.
- `i_rxSerial`: input, 1 bit, raw serial line. It is asynchronous and idles high.
- `i_errorClear`: input, 1 bit, synchronous clear for `o_errorSticky`.
- `o_rxData`: output, 8 bits, last good byte, received LSB first. It is held until the next good byte.
- `o_rxDone`: output, 1 bit, one-cycle pulse when `o_rxData` is updated.
- `o_rxBusy`: output, 1 bit, high in every state except IDLE.
- `o_frameError`: output, 1 bit, one-cycle pulse on a bad stop bit.
- `o_break`: output, 1 bit, one-cycle pulse, coincident with `o_frameError`, when the data bits and stop bit are all 0.
- `o_errorSticky`: output, 1 bit, set by `o_frameError` and cleared by `i_errorClear` or reset.

## Operation
- **Input synchroniser:** two-flop synchroniser on `i_rxSerial`, giving `rxSync`. Both flops reset to 1.
- **Bit counter:** `$clog2(CLOCKS_PER_BIT)` bits wide. It resets to 0 on every state entry and on every sample point.
- **State machine:** states are IDLE, START, DATA, STOP and WAIT_IDLE.
- **IDLE:** when `rxSync` is 0, go to START.
- **START:** count to `CLOCKS_PER_BIT/2` (integer division), then sample `rxSync`.
  - If 1, the start was a glitch. Return to IDLE with no error and no pulse.
  - If 0, go to DATA with bit index 0.
- **DATA:** every `CLOCKS_PER_BIT` cycles, sample `rxSync` into the shift register at position `index`, LSB first. After index 7, go to STOP.
- **STOP:** after `CLOCKS_PER_BIT` cycles, sample `rxSync`.
  - If 1, load `o_rxData` from the shift register, pulse `o_rxDone`, and go to IDLE.
  - If 0, pulse `o_frameError` and set `o_errorSticky`. Also pulse `o_break` if all 8 data bits were 0. `o_rxData` is NOT updated. Go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rxSync` is 1, then go to IDLE. No new start can be detected while the line is held low.
- **Early return to IDLE:** the block returns to IDLE at the middle of the stop bit. A following start edge is therefore accepted from half a bit onward, which tolerates sender and receiver clock mismatch.
- **`i_errorClear` and a new error in the same cycle:** the set wins, so `o_errorSticky` stays 1.
- **Reset mid-frame:** the state goes to IDLE immediately. The partial byte is discarded, with no pulses. `o_rxData` becomes 0x00 and `o_errorSticky` becomes 0.
- **Reset values of all outputs:** `o_rxData` = 0x00; `o_rxDone`, `o_rxBusy`, `o_frameError`, `o_break` and `o_errorSticky` are all 0.

## Timing
- **Synchroniser latency:** 2 cycles from a pin edge to `rxSync`.
- **Reference point t0:** the first `i_clock` edge at which `rxSync` = 0 in IDLE. START is entered at t0+1.
- **Sample points:**
  - Start sample at t0+1+`CLOCKS_PER_BIT/2`.
  - Data bit k (k = 0…7) at t0+1+`CLOCKS_PER_BIT/2`+(k+1)·`CLOCKS_PER_BIT`.
  - Stop sample at t0+1+`CLOCKS_PER_BIT/2`+9·`CLOCKS_PER_BIT`.
- **Result outputs:** `o_rxDone`, `o_frameError` and `o_break` are registered. They are high for exactly the one cycle after the stop sample, and `o_rxData` becomes valid in that same cycle.
- **Busy flag:** `o_rxBusy` rises at t0+1 and falls in the cycle after the stop sample. On a glitched start it falls in the cycle after the start sample.
- **Consecutive strobes:** the minimum spacing between two `o_rxDone` pulses is about 9.5·`CLOCKS_PER_BIT` cycles.

## Test plan
- **Single byte:** drive 0xA5 (8N1) at `CLOCKS_PER_BIT`=1000. Required: `o_rxData`=0xA5, one `o_rxDone` pulse at t0+1+500+9000+1, and no error outputs.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap, then 0x55 with the sender 2% fast. Required: three `o_rxDone` pulses with data 0x00, 0xFF, 0x55, and `o_errorSticky`=0.
- **Glitch rejection:** drive a 200-cycle low pulse on an idle line. Required: `o_rxBusy` high for about 501 cycles, then IDLE. No `o_rxDone` and no errors.
- **Framing error and clear:** send 0x3C with stop=0, then return high. Required: `o_frameError` pulses, `o_break`=0, `o_rxData` keeps its previous value, `o_errorSticky`=1. A subsequent `i_errorClear` pulse returns `o_errorSticky` to 0.
- **Break:** hold the line low for 20 bit times. Required: one `o_frameError` pulse and one `o_break` pulse, the FSM stays in WAIT_IDLE until the line rises, and the next 0x81 is received correctly.
- **Reset mid-frame and loopback:**
  - Assert `i_resetN`=0 during DATA bit 4. Required: all outputs return to their reset values immediately, with no pulse afterwards.
  - Loop back from `uart_tx` with 256 random bytes. Required: every byte matches and there are zero errors.
